// File: rtl/knn_vote_collector.sv
// KNN vote collector: keeps the K nearest labelled distances of a query in a sorted
// insertion register, then majority-votes the retained labels into one result.
module knn_vote_collector #(
   parameter int K         = 3,
   parameter int W         = 32,
   parameter int NUM_TYPES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_distance,
   input  logic [W-1:0] in_type,
   input  logic         in_last,
   output logic         result_valid,
   input  logic         result_ready,
   output logic [W-1:0] result_type,
   output logic [3:0]   result_count,
   output logic [W-1:0] result_min_distance,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_t;

   state_t       state;
   logic [W-1:0] slot_dist [K];
   logic [W-1:0] slot_type [K];
   logic [K-1:0] slot_valid;
   logic [3:0]   vote_cnt  [NUM_TYPES];

   logic [K-1:0] gt;
   logic [W-1:0] nxt_dist  [K];
   logic [W-1:0] nxt_type  [K];
   logic [K-1:0] nxt_valid;
   logic [3:0]   cnt_c     [NUM_TYPES];
   logic [W-1:0] win_type;
   logic [3:0]   win_cnt;

   // gt is monotonic because slots stay sorted and valid entries are contiguous, so the
   // first set bit marks the insertion point; equal distances land behind older entries.
   always_comb begin
      for (int unsigned i = 0; i < K; i++) begin
         gt[i]        = !slot_valid[i] || (slot_dist[i] > in_distance);
         nxt_dist[i]  = slot_dist[i];
         nxt_type[i]  = slot_type[i];
         nxt_valid[i] = slot_valid[i];
      end
      if (gt[0]) begin
         nxt_dist[0]  = in_distance;
         nxt_type[0]  = in_type;
         nxt_valid[0] = 1'b1;
      end
      for (int unsigned i = 1; i < K; i++) begin
         if (gt[i] && gt[i-1]) begin
            nxt_dist[i]  = slot_dist[i-1];
            nxt_type[i]  = slot_type[i-1];
            nxt_valid[i] = slot_valid[i-1];
         end else if (gt[i]) begin
            nxt_dist[i]  = in_distance;
            nxt_type[i]  = in_type;
            nxt_valid[i] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_TYPES; c++) begin
         cnt_c[c] = '0;
         for (int unsigned i = 0; i < K; i++)
            if (slot_valid[i] && slot_type[i] == W'(c))
               cnt_c[c] = cnt_c[c] + 4'd1;
      end
   end

   // Scanning slots nearest-first with a strict compare resolves ties to the nearest slot.
   always_comb begin
      win_type = '0;
      win_cnt  = '0;
      for (int unsigned i = 0; i < K; i++)
         for (int unsigned c = 0; c < NUM_TYPES; c++)
            if (slot_valid[i] && slot_type[i] == W'(c) && vote_cnt[c] > win_cnt) begin
               win_cnt  = vote_cnt[c];
               win_type = W'(c);
            end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         in_ready            <= 1'b0;
         result_valid        <= 1'b0;
         result_type         <= '0;
         result_count        <= '0;
         result_min_distance <= '0;
         busy                <= 1'b0;
         slot_valid          <= '0;
         for (int unsigned i = 0; i < K; i++) begin
            slot_dist[i] <= '0;
            slot_type[i] <= '0;
         end
         for (int unsigned c = 0; c < NUM_TYPES; c++)
            vote_cnt[c] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= COLLECT;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  slot_valid <= '0;
               end
            end
            COLLECT: begin
               if (in_valid && in_ready) begin
                  slot_dist  <= nxt_dist;
                  slot_type  <= nxt_type;
                  slot_valid <= nxt_valid;
                  if (in_last) begin
                     state    <= VOTE;
                     in_ready <= 1'b0;
                  end
               end
            end
            VOTE: begin
               vote_cnt <= cnt_c;
               state    <= DONE;
            end
            DONE: begin
               if (!result_valid) begin
                  result_valid        <= 1'b1;
                  result_type         <= win_type;
                  result_count        <= win_cnt;
                  result_min_distance <= slot_dist[0];
               end else if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_vote_collector.sv
// Directed table-driven bench for knn_vote_collector (K=3, W=32, NUM_TYPES=4), plus
// hand-written backpressure and mid-query reset sequences.
module tb_knn_vote_collector;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_last, result_ready;
   logic        in_ready, result_valid, busy;
   logic [31:0] in_distance, in_type, result_type, result_min_distance;
   logic [3:0]  result_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int              n;
      logic [5:0][31:0] d;
      logic [5:0][31:0] t;
      logic [31:0]     et;
      logic [3:0]      ec;
      logic [31:0]     em;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   knn_vote_collector #(.K(3), .W(32), .NUM_TYPES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_distance(in_distance), .in_type(in_type), .in_last(in_last),
      .result_valid(result_valid), .result_ready(result_ready), .result_type(result_type),
      .result_count(result_count), .result_min_distance(result_min_distance), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
      end
   endtask

   task automatic add(input int v, input logic [31:0] d, input logic [31:0] t);
      vecs[v].d[vecs[v].n] = d;
      vecs[v].t[vecs[v].n] = t;
      vecs[v].n++;
   endtask

   task automatic expect_res(input int v, input logic [31:0] et, input logic [3:0] ec,
                             input logic [31:0] em);
      vecs[v].et = et;
      vecs[v].ec = ec;
      vecs[v].em = em;
   endtask

   // Starts a query, streams all samples of vector v, and waits for result_valid.
   task automatic run_query(input int v);
      int cyc;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int j = 0; j < vecs[v].n; j++) begin
         in_valid    = 1'b1;
         in_distance = vecs[v].d[j];
         in_type     = vecs[v].t[j];
         in_last     = (j == vecs[v].n - 1);
         chk($sformatf("v%0d_in_ready_%0d", v, j), {31'd0, in_ready}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      cyc = 0;
      while (!result_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("v%0d_latency", v), cyc, 2);
   endtask

   task automatic check_result(input int v);
      chk($sformatf("v%0d_type", v), result_type, vecs[v].et);
      chk($sformatf("v%0d_count", v), {28'd0, result_count}, {28'd0, vecs[v].ec});
      chk($sformatf("v%0d_min", v), result_min_distance, vecs[v].em);
   endtask

   task automatic accept_result(input int v);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk($sformatf("v%0d_rv_drop", v), {31'd0, result_valid}, 32'd0);
      chk($sformatf("v%0d_idle", v), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      for (int v = 0; v < NV; v++) begin
         vecs[v].n = 0;
         vecs[v].d = '0;
         vecs[v].t = '0;
      end
      add(0, 10, 1); add(0, 5, 2); add(0, 7, 2);                  expect_res(0, 2, 2, 5);
      add(1, 50, 0); add(1, 40, 0); add(1, 30, 0);
      add(1, 20, 1); add(1, 10, 1); add(1, 60, 3);                expect_res(1, 1, 2, 10);
      add(2, 9, 3); add(2, 4, 0); add(2, 12, 1);                  expect_res(2, 0, 1, 4);
      add(3, 8, 2); add(3, 8, 1); add(3, 8, 1); add(3, 8, 0);     expect_res(3, 1, 2, 8);
      add(4, 3, 7); add(4, 5, 2); add(4, 6, 9);                   expect_res(4, 2, 1, 3);
      add(5, 2, 5); add(5, 4, 4);                                 expect_res(5, 0, 0, 2);
      add(6, 3, 1);                                               expect_res(6, 1, 1, 3);
      add(7, 100, 2); add(7, 90, 1); add(7, 95, 2); add(7, 80, 1); expect_res(7, 1, 2, 80);
      add(8, 32'hFFFF_FFFF, 3); add(8, 0, 2);                     expect_res(8, 2, 1, 0);

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; result_ready = 1'b0;
      in_distance = '0; in_type = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_rv", {31'd0, result_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_type", result_type, 32'd0);
      chk("rst_count", {28'd0, result_count}, 32'd0);
      chk("rst_min", result_min_distance, 32'd0);

      for (int v = 0; v < NV; v++) begin
         run_query(v);
         check_result(v);
         accept_result(v);
      end

      // Backpressure: result held for 5 cycles, start pulses ignored.
      run_query(0);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         @(negedge clk);
         chk("bp_rv", {31'd0, result_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
         check_result(0);
      end
      start = 1'b0;
      accept_result(0);
      @(negedge clk);
      chk("bp_start_ignored", {31'd0, busy}, 32'd0);

      // Reset in the middle of a query discards the partial slot contents.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      in_valid = 1'b1; in_distance = 1; in_type = 2; in_last = 1'b0;
      @(negedge clk);
      in_distance = 2; in_type = 2;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mrst_rv", {31'd0, result_valid}, 32'd0);
      chk("mrst_type", result_type, 32'd0);
      chk("mrst_count", {28'd0, result_count}, 32'd0);
      chk("mrst_min", result_min_distance, 32'd0);
      run_query(6);
      check_result(6);
      accept_result(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/knn_vote_collector.md
Name: knn_vote_collector

Overview:
- Downstream consumer of the distance_calculator result stream (distance, data_type pairs) in the KNN system.
- Accepts one labelled distance per cycle over a valid/ready handshake and keeps the K smallest distances in a sorted insertion register.
- When the last sample of a query arrives, runs a majority vote over the retained neighbours and presents the winning class with a valid/ready result handshake.

Parameters:
- K, 3, number of nearest neighbours retained (1..8)
- W, 32, width of distance and type words (matches distance_calculator W)
- NUM_TYPES, 4, number of legal class labels (0..NUM_TYPES-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a new query; honoured only in IDLE
- in_valid  in  1  in_distance/in_type/in_last valid
- in_ready  out  1  collector can accept a sample
- in_distance  in  W  unsigned distance from distance_calculator
- in_type  in  W  class label of the training vector
- in_last  in  1  marks final sample of the query
- result_valid  out  1  result fields valid
- result_ready  in  1  downstream accepts result
- result_type  out  W  winning class label
- result_count  out  4  votes received by the winning class
- result_min_distance  out  W  smallest distance seen in the query
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; in_ready=0, result_valid=0, result_type=0, result_count=0, result_min_distance=0, busy=0; all K slots invalid.
- Reset asserted in any state (including mid-query or while result_valid is high) aborts the query and discards the slots.
- States:
  - IDLE: start → COLLECT; slots cleared in the same edge. start in other states is ignored.
  - COLLECT: in_ready=1. A transfer occurs when in_valid && in_ready. A transfer with in_last=1 → VOTE.
  - VOTE: single cycle, in_ready=0. Counts are computed and registered; next state DONE.
  - DONE: result_valid=1 and outputs held stable until result_valid && result_ready; then → IDLE, with result_valid=0 on the following cycle. Result fields keep their values until the next VOTE.
- Latency: in_last accepted at edge t → result_valid high after edge t+2.
- Insertion (one per accepted sample, single cycle):
  - The new sample goes in at the position of the first valid slot whose distance is strictly greater than it, or into the first invalid slot.
  - Later slots shift down by one; the slot K-1 entry is dropped.
  - If every slot is valid and in_distance >= slot[K-1], the sample is discarded.
  - Equal distances: the earlier-arrived sample stays nearer (stable ordering).
- Samples with in_type >= NUM_TYPES are inserted by distance but carry no vote.
- result_min_distance = minimum in_distance over all accepted samples, equal to slot[0] at VOTE.
- Vote:
  - count[c] = number of valid slots with type c.
  - Winner = class with the maximum count.
  - Tie: the class of the lowest-index (nearest) slot among the tied classes wins.
  - If no valid slot has a legal type: result_type=0, result_count=0.
- Fewer than K samples in a query: only the valid slots vote.
- Distances are unsigned W-bit; comparisons are unsigned; no saturation needed.
- busy = (state != IDLE).

Test Plan:
- Reset then start, K=3; send (10,t1),(5,t2),(7,t2 last) → result_type=2, result_count=2, result_min_distance=5, result_valid high 2 cycles after the last transfer.
- Send 6 samples (d=50,40,30,20,10,60; types 0,0,0,1,1,3) → slots {10,20,30}; winner type 1, count 2; min 10.
- Tie: send (9,t3),(4,t0),(12,t1 last) → all counts 1; winner type 0 (nearest), count 1.
- Equal distances (8,t2),(8,t1),(8,t1),(8,t0 last) → slots t2,t1,t1 (t0 discarded); winner t1, count 2.
- Backpressure: hold result_ready=0 for 5 cycles → result_valid and fields stable, in_ready=0, start ignored; result_ready=1 → IDLE next cycle.
- Assert rst in COLLECT after 2 samples → all outputs 0, IDLE; new query (3,t1 last) → result_type=1, count=1, min=3.
